// File: rtl/ro_cnt_pkg.sv
// Shared types and default sizes for the ring-oscillator frequency counter.
package ro_cnt_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int WIN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// One ring-oscillator channel: 2-flop synchroniser plus a registered rising-edge
// detector producing a single-cycle pulse three clocks after ro_i rises.
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ro_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;

    // Pulses are only reliable when ro_i holds each level for at least two clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Gated multi-channel ring-oscillator edge counter with single/continuous windows.
// Define RO_CNT_SAT_EN to make accumulators saturate instead of wrapping.
module ro_freq_counter
    import ro_cnt_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WIN_W  = WIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ro_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    cont_i,
    input  logic [WIN_W-1:0]        win_len_i,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH-1:0]       ovf_o,
    output logic                    valid_o,
    output logic                    busy_o
);

    state_t                    state_q;
    logic [1:0]                rstSync_q;
    logic [WIN_W-1:0]          winCnt_q;
    logic [WIN_W-1:0]          winLen_q;
    logic [CNT_W-1:0]          acc_q [NUM_CH];
    logic [CNT_W-1:0]          acc_d [NUM_CH];
    logic [NUM_CH-1:0]         accOvf_q;
    logic [NUM_CH-1:0]         accOvf_d;
    logic [NUM_CH*CNT_W-1:0]   count_q;
    logic [NUM_CH-1:0]         ovf_q;
    logic                      valid_q;
    logic                      busy_q;
    logic [NUM_CH-1:0]         edgePulse;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_sync
        ro_edge_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .ro_i   (ro_i[g]),
            .edge_o (edgePulse[g])
        );
    end

    // Next accumulator values for one RUN cycle; the overflow flag is sticky per window.
    always_comb begin
        accOvf_d = accOvf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            if (edgePulse[i]) begin
                if (acc_q[i] == '1) begin
                    accOvf_d[i] = 1'b1;
`ifdef RO_CNT_SAT_EN
                    acc_d[i] = '1;
`else
                    acc_d[i] = '0;
`endif
                end else begin
                    acc_d[i] = acc_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // rstSync_q[1] rises two edges after reset release; starts are held off until then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rstSync_q <= '0;
            winCnt_q  <= '0;
            winLen_q  <= '0;
            accOvf_q  <= '0;
            count_q   <= '0;
            ovf_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
            valid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && rstSync_q[1] && (win_len_i != '0)) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        winLen_q <= win_len_i;
                        winCnt_q <= win_len_i;
                        accOvf_q <= '0;
                        for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
                        accOvf_q <= accOvf_d;
                        winCnt_q <= winCnt_q - WIN_W'(1);
                        if (winCnt_q == WIN_W'(1)) state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) count_q[i*CNT_W +: CNT_W] <= acc_q[i];
                        ovf_q   <= accOvf_q;
                        valid_q <= 1'b1;
                        if (cont_i) begin
                            state_q  <= RUN;
                            winCnt_q <= winLen_q;
                            accOvf_q <= '0;
                            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter (NUM_CH=2, CNT_W=8, WIN_W=16) with random
// oscillator phases/periods checked against a rise-log based window model.
module tb_ro_freq_counter;

    localparam int NCH   = 2;
    localparam int CW    = 8;
    localparam int WW    = 16;
    localparam int HSIZE = 16384;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ro_i;
    logic              start_i;
    logic              abort_i;
    logic              cont_i;
    logic [WW-1:0]     win_len_i;
    logic [NCH*CW-1:0] count_o;
    logic [NCH-1:0]    ovf_o;
    logic              valid_o;
    logic              busy_o;

    int cyc = 0;
    int sCyc = 0;
    int nCompared = 0;
    int nMismatched = 0;

    bit             roEn = 1'b0;
    int             per [NCH];
    int             hi  [NCH];
    int             ph  [NCH];
    logic [NCH-1:0] roPrev = '0;
    logic [NCH-1:0] riseAt [HSIZE];
    int             expCnt [NCH];
    bit             expOvf [NCH];

    ro_freq_counter #(.NUM_CH(NCH), .CNT_W(CW), .WIN_W(WW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ro_i      (ro_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .cont_i    (cont_i),
        .win_len_i (win_len_i),
        .count_o   (count_o),
        .ovf_o     (ovf_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Square-wave oscillators driven at the falling edge; every rise is logged by cycle.
    always @(negedge clk) begin
        logic nv;
        for (int c = 0; c < NCH; c++) begin
            nv = roEn && (((cyc + ph[c]) % per[c]) < hi[c]);
            if (nv && !roPrev[c] && cyc < HSIZE) riseAt[cyc][c] = 1'b1;
            roPrev[c] = nv;
            ro_i[c]   = nv;
        end
    end

    // A rise logged at cycle n is counted by the DUT on clock edge n+4.
    task automatic computeExpect(input int firstEdge, input int lastEdge);
        int n;
        for (int c = 0; c < NCH; c++) begin
            n = 0;
            for (int k = firstEdge - 4; k <= lastEdge - 4; k++)
                if (k >= 0 && k < HSIZE && riseAt[k][c]) n++;
            expOvf[c] = (n > 255);
`ifdef RO_CNT_SAT_EN
            expCnt[c] = (n > 255) ? 255 : n;
`else
            expCnt[c] = n % 256;
`endif
        end
    endtask

    task automatic setRo(input int c, input int p, input int h);
        per[c] = p;
        hi[c]  = h;
        ph[c]  = $urandom_range(0, p - 1);
    endtask

    task automatic startWindow(input int w);
        start_i   = 1'b1;
        win_len_i = WW'(w);
        sCyc      = cyc + 1;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic waitValid(input int limit, output int lat);
        lat = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                lat = cyc - sCyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nCompared++; if (count_o !== '0) begin nMismatched++; $display("[TB] FAIL reset_count: got %h expected 0", count_o); end
        nCompared++; if (ovf_o !== '0) begin nMismatched++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf_o); end
        nCompared++; if (valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        nCompared++; if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic checkWindow(input string name, input int w, input int lat);
        nCompared++;
        if (lat !== w + 1) begin nMismatched++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, w + 1); end
        computeExpect(sCyc + 1, sCyc + w);
        for (int c = 0; c < NCH; c++) begin
            nCompared++;
            if (count_o[c*CW +: CW] !== CW'(expCnt[c])) begin
                nMismatched++;
                $display("[TB] FAIL %s_count%0d: got %0d expected %0d", name, c, count_o[c*CW +: CW], expCnt[c]);
            end
            nCompared++;
            if (ovf_o[c] !== expOvf[c]) begin
                nMismatched++;
                $display("[TB] FAIL %s_ovf%0d: got %b expected %b", name, c, ovf_o[c], expOvf[c]);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        setRo(0, 4, 2);
        setRo(1, 8, 4);
        roEn = 1'b1;
        repeat (12) @(negedge clk);
        startWindow(100);
        waitValid(200, lat);
        checkWindow("basic", 100, lat);
        nCompared++;
        if (count_o[CW-1:0] !== 8'd25) begin nMismatched++; $display("[TB] FAIL basic_ch0_25: got %0d expected 25", count_o[CW-1:0]); end
    endtask

    task automatic test_random();
        int lat;
        int w;
        int p;
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < NCH; c++) begin
                p = $urandom_range(4, 12);
                setRo(c, p, $urandom_range(2, p - 2));
            end
            w = (it == 0) ? 1 : $urandom_range(20, 300);
            repeat (10) @(negedge clk);
            startWindow(w);
            waitValid(w + 20, lat);
            checkWindow("random", w, lat);
        end
    endtask

    task automatic test_overflow();
        int lat;
        setRo(0, 4, 2);
        setRo(1, 10, 5);
        repeat (10) @(negedge clk);
        startWindow(1200);
        waitValid(1300, lat);
        checkWindow("overflow", 1200, lat);
    endtask

    task automatic test_continuous();
        int lat;
        int nValid;
        setRo(0, 4, 2);
        setRo(1, 6, 3);
        repeat (10) @(negedge clk);
        cont_i = 1'b1;
        startWindow(50);
        for (int w = 0; w < 3; w++) begin
            waitValid(80, lat);
            checkWindow("cont", 50, lat);
            sCyc = cyc;
            if (w == 1) cont_i = 1'b0;
        end
        nCompared++;
        if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL cont_stop_busy: got %b expected 0", busy_o); end
        nValid = 0;
        repeat (60) begin @(negedge clk); if (valid_o === 1'b1) nValid++; end
        nCompared++;
        if (nValid !== 0) begin nMismatched++; $display("[TB] FAIL cont_stop_valid: got %0d pulses expected 0", nValid); end
    endtask

    task automatic test_abort();
        int nValid;
        startWindow(100);
        repeat (29) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        nCompared++;
        if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_o); end
        nValid = 0;
        repeat (120) begin @(negedge clk); if (valid_o === 1'b1) nValid++; end
        nCompared++;
        if (nValid !== 0) begin nMismatched++; $display("[TB] FAIL abort_valid: got %0d pulses expected 0", nValid); end
        for (int c = 0; c < NCH; c++) begin
            nCompared++;
            if (count_o[c*CW +: CW] !== CW'(expCnt[c]) || ovf_o[c] !== expOvf[c]) begin
                nMismatched++;
                $display("[TB] FAIL abort_hold%0d: got %0d/%b expected %0d/%b", c, count_o[c*CW +: CW], ovf_o[c], expCnt[c], expOvf[c]);
            end
        end
    endtask

    task automatic test_zero_and_restart();
        int lat;
        startWindow(0);
        repeat (3) @(negedge clk);
        nCompared++;
        if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL zero_len_busy: got %b expected 0", busy_o); end
        startWindow(60);
        repeat (10) @(negedge clk);
        start_i   = 1'b1;
        win_len_i = WW'(10);
        @(negedge clk);
        start_i   = 1'b0;
        waitValid(100, lat);
        checkWindow("restart_ignored", 60, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        startWindow(100);
        repeat (39) @(negedge clk);
        rst = 1'b0;
        #1;
        nCompared++; if (count_o !== '0) begin nMismatched++; $display("[TB] FAIL midrst_count: got %h expected 0", count_o); end
        nCompared++; if (ovf_o !== '0) begin nMismatched++; $display("[TB] FAIL midrst_ovf: got %b expected 0", ovf_o); end
        nCompared++; if (valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_valid: got %b expected 0", valid_o); end
        nCompared++; if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy_o); end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        startWindow(30);
        waitValid(60, lat);
        checkWindow("after_rst", 30, lat);
    endtask

    initial begin
        ro_i      = '0;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        cont_i    = 1'b0;
        win_len_i = '0;
        for (int c = 0; c < NCH; c++) begin per[c] = 4; hi[c] = 2; ph[c] = 0; expCnt[c] = 0; expOvf[c] = 1'b0; end
        for (int k = 0; k < HSIZE; k++) riseAt[k] = '0;
        test_reset();
        test_basic();
        test_random();
        test_overflow();
        test_continuous();
        test_abort();
        test_zero_and_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
